// File: rtl/mux12_scanner.sv
// Steps a 1-bit mux through its channels with a settle delay, sampling each into a shadow word
// and publishing an N-bit snapshot with a one-cycle valid pulse; optional back-to-back scanning.
module mux12_scanner #(
  parameter int unsigned N      = 12,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic             mux_y_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             busy_o,
  output logic [N-1:0]     data_o,
  output logic             valid_o
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample} state_e;

  // With no settle time every channel goes straight to its sampling cycle.
  localparam state_e           ScanEntry  = (SETTLE == 0) ? StSample : StSettle;
  localparam logic [3:0]       SettleLast = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [SEL_W-1:0] SelLast    = SEL_W'(N - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     data_q, data_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [N-1:0]     merged;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    // Shadow plus the bit being sampled now, so the last channel lands in data in the same edge.
    merged          = shadow_q;
    merged[sel_q]   = mux_y_i;

    unique case (state_q)
      StIdle: begin
        sel_d = '0;
        if (start_i) begin
          state_d = ScanEntry;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        shadow_d = merged;
        cnt_d    = '0;
        if (sel_q != SelLast) begin
          sel_d   = sel_q + 1'b1;
          state_d = ScanEntry;
        end else begin
          data_d  = merged;
          valid_d = 1'b1;
          sel_d   = '0;
          if (cont_i) begin
            state_d = ScanEntry;
          end else begin
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign sel_o   = sel_q;
  assign busy_o  = busy_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_mux12_scanner.sv
// Bench for mux12_scanner: a SETTLE=1 and a SETTLE=0 instance driven by a mux pattern model,
// with snapshots checked against a queue of expected {data, cycle} entries.
module tb_mux12_scanner;

  typedef struct {
    logic [11:0] pat;
    logic        mask;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    logic [11:0] data;
    int          cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start1 = 1'b0, cont1 = 1'b0, mask1 = 1'b0;
  logic        start0 = 1'b0, cont0 = 1'b0;
  logic [11:0] pat1 = '0, pat0 = '0;
  logic        mux_y1, mux_y0;
  logic [3:0]  sel1, sel0;
  logic        busy1, busy0, valid1, valid0;
  logic [11:0] data1, data0;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  ph = 0;
  sb_t q1[$];
  sb_t q0[$];
  sb_t e1, e0;
  vec_t vecs[5];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Phase since scan start: even = settle cycle, odd = sample cycle (SETTLE=1 instance).
  always @(posedge clk) begin
    if (start1 && !busy1) ph <= 0;
    else ph <= ph + 1;
  end

  assign mux_y1 = pat1[sel1] ^ (mask1 & ~ph[0]);
  assign mux_y0 = pat0[sel0];

  mux12_scanner #(.N(12), .SEL_W(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .cont_i(cont1), .mux_y_i(mux_y1),
    .sel_o(sel1), .busy_o(busy1), .data_o(data1), .valid_o(valid1)
  );

  mux12_scanner #(.N(12), .SEL_W(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .cont_i(cont0), .mux_y_i(mux_y0),
    .sel_o(sel0), .busy_o(busy0), .data_o(data0), .valid_o(valid0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb1 unexpected valid: got data %h want no valid (cycle %0d)", data1, cyc);
      end else begin
        e1 = q1.pop_front();
        check("sb1 data", 32'(data1), 32'(e1.data));
        check("sb1 valid cycle", cyc, e1.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid0 === 1'b1) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb0 unexpected valid: got data %h want no valid (cycle %0d)", data0, cyc);
      end else begin
        e0 = q0.pop_front();
        check("sb0 data", 32'(data0), 32'(e0.data));
        check("sb0 valid cycle", cyc, e0.cyc);
      end
    end
  end

  task automatic run_scan(input logic [11:0] p, input logic m, input logic [11:0] exp);
    pat1   = p;
    mask1  = m;
    start1 = 1'b1;
    q1.push_back('{exp, cyc + 1 + 24});
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      check("scan sel", 32'(sel1), k / 2);
      check("scan busy", 32'(busy1), 1);
      check("scan valid low", 32'(valid1), 0);
      @(negedge clk);
    end
    check("end valid", 32'(valid1), 1);
    check("end busy", 32'(busy1), 0);
    check("end sel", 32'(sel1), 0);
    @(negedge clk);
    check("post valid", 32'(valid1), 0);
    check("post data hold", 32'(data1), 32'(exp));
  endtask

  initial begin
    vecs[0] = '{12'hA5C, 1'b0, 12'hA5C};
    vecs[1] = '{12'hA5C, 1'b1, 12'hA5C};
    vecs[2] = '{12'h000, 1'b1, 12'h000};
    vecs[3] = '{12'h3C3, 1'b0, 12'h3C3};
    vecs[4] = '{12'h5A6, 1'b1, 12'h5A6};

    #3 rst_n = 1'b0;
    #1;
    check("rst sel", 32'(sel1), 0);
    check("rst busy", 32'(busy1), 0);
    check("rst valid", 32'(valid1), 0);
    check("rst data", 32'(data1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_scan(vecs[i].pat, vecs[i].mask, vecs[i].exp);
      repeat (2) @(negedge clk);
    end

    // Start while busy: pulses mid-scan and in the last sample cycle are dropped.
    pat1   = 12'hA5C;
    mask1  = 1'b0;
    start1 = 1'b1;
    q1.push_back('{12'hA5C, cyc + 1 + 24});
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 60; k++) begin
      start1 = (k == 5 || k == 23);
      if (k < 24) check("swb busy high", 32'(busy1), 1);
      else check("swb busy low", 32'(busy1), 0);
      @(negedge clk);
    end
    start1 = 1'b0;
    check("swb data", 32'(data1), 32'h0A5C);

    // Continuous mode, two back-to-back scans then stop.
    pat1   = 12'h0F0;
    cont1  = 1'b1;
    start1 = 1'b1;
    q1.push_back('{12'h0F0, cyc + 1 + 24});
    q1.push_back('{12'h123, cyc + 1 + 48});
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 48; k++) begin
      check("cont busy", 32'(busy1), 1);
      if (k == 24) pat1 = 12'h123;
      if (k == 30) cont1 = 1'b0;
      @(negedge clk);
    end
    check("cont last valid", 32'(valid1), 1);
    check("cont busy drop", 32'(busy1), 0);
    repeat (30) @(negedge clk);
    check("cont stays idle", 32'(busy1), 0);
    check("cont data hold", 32'(data1), 32'h0123);

    // Reset mid-scan after a full-ones snapshot.
    run_scan(12'hFFF, 1'b0, 12'hFFF);
    pat1   = 12'h0F0;
    start1 = 1'b1;
    q1.push_back('{12'h0F0, cyc + 1 + 24});
    @(negedge clk);
    start1 = 1'b0;
    repeat (12) @(negedge clk);
    check("mid sel", 32'(sel1), 6);
    #2 rst_n = 1'b0;
    q1.delete();
    #1;
    check("mid rst sel", 32'(sel1), 0);
    check("mid rst busy", 32'(busy1), 0);
    check("mid rst valid", 32'(valid1), 0);
    check("mid rst data", 32'(data1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("mid idle busy", 32'(busy1), 0);
    check("mid idle data", 32'(data1), 0);
    run_scan(12'hA5C, 1'b0, 12'hA5C);

    // SETTLE = 0 instance.
    pat0   = 12'h801;
    start0 = 1'b1;
    q0.push_back('{12'h801, cyc + 1 + 12});
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check("s0 sel", 32'(sel0), k);
      check("s0 busy", 32'(busy0), 1);
      @(negedge clk);
    end
    check("s0 valid", 32'(valid0), 1);
    check("s0 data", 32'(data0), 32'h0801);
    @(negedge clk);
    check("s0 valid low", 32'(valid0), 0);
    check("s0 busy low", 32'(busy0), 0);

    repeat (3) @(negedge clk);
    check("q1 drained", q1.size(), 0);
    check("q0 drained", q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux12_scanner.md
# mux12_scanner

Sequencer that sits directly around the 12:1 select mux: it drives the mux's 4-bit select through every channel in order, waits a programmable settle time, samples the mux's single-bit output, and assembles the 12 sampled bits into a parallel word. It turns a one-bit mux into a registered 12-bit snapshot with a start/valid handshake and an optional free-running mode.

## Interface

**Parameters**
- `N`, default 12: number of mux channels scanned; legal range 2..16.
- `SEL_W`, default 4: select width; must satisfy 2**SEL_W >= N.
- `SETTLE`, default 1: wait cycles after each select change before sampling; legal range 0..15.

**Ports**
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a scan; sampled only in IDLE.
- `cont`, in, 1: continuous mode; when high at scan end, the next scan begins immediately.
- `mux_y`, in, 1: output of the 12:1 mux.
- `sel`, out, SEL_W: select driven to the mux; registered.
- `busy`, out, 1: scan in progress.
- `data`, out, N: last completed snapshot; bit i is the value sampled with `sel` = i.
- `valid`, out, 1: one-cycle pulse when `data` updates.

## Operation

- **Reset values** (asynchronous on `rst_n` = 0): state IDLE, `sel` = 0, `busy` = 0, `valid` = 0, `data` = 0, internal shadow register = 0, settle counter = 0.
- **FSM states:** IDLE, SETTLE, SAMPLE.
- **IDLE:**
  - `sel` is held at 0.
  - `start` = 1 moves the FSM to SETTLE, or to SAMPLE if SETTLE = 0.
  - On that move: `busy` goes to 1, `sel` goes to 0, and the counter clears.
- **SETTLE:** the counter increments each cycle. When the counter reaches SETTLE-1, the FSM moves to SAMPLE.
- **SAMPLE** (exactly one cycle): at the closing edge, shadow[`sel`] takes `mux_y`. Then:
  - **`sel` < N-1:** `sel` increments by 1, the counter clears, and the FSM returns to SETTLE (or stays in SAMPLE if SETTLE = 0).
  - **`sel` = N-1:**
    - `data` takes the shadow contents with the final bit merged in the same edge.
    - `valid` goes to 1 for one cycle.
    - `sel` goes to 0.
    - If `cont` = 1: `busy` stays 1 and the FSM moves to SETTLE/SAMPLE to begin a new scan.
    - Otherwise: `busy` goes to 0 and the FSM moves to IDLE.
- **Sampling window:** `mux_y` is only observed at the SAMPLE closing edge. Values during SETTLE are ignored.
- **Select range:** `sel` never exceeds N-1. Unused upper mux inputs are never selected.
- **Start while busy:** `start` is ignored while `busy` = 1. It is not queued.
- **Data stability:** `data` changes only on the `valid` edge and holds between scans, including while a new scan is running.
- **Reset mid-scan:** aborts immediately. The partial shadow is discarded and `data` returns to 0.

## Timing

- Let E0 be the edge at which `start` is accepted.
- Per channel, the scanner spends SETTLE+1 cycles.
- `valid` is high in the cycle following edge E0 + N·(SETTLE+1).
  - For N = 12, SETTLE = 1: 24 edges after E0.
  - For N = 12, SETTLE = 0: 12 edges after E0.
- `sel` = k from edge E0 + k·(SETTLE+1) until the next change.
- `busy` rises at E0.
  - Non-continuous mode: `busy` falls on the same edge `valid` rises.
  - Continuous mode: `busy` stays high.
- Continuous mode has back-to-back scans with no idle cycle. `valid` pulses every N·(SETTLE+1) cycles.
- `start` asserted in the same cycle `busy` falls (the last SAMPLE cycle) is ignored. The earliest restart is `start` sampled in the first IDLE cycle.
- **Path constraint:** the mux is combinational, so `sel` → `mux_y` must settle within (SETTLE+1) clock periods. No combinational path exists from inputs to outputs.

## Test plan

- **Reset:** assert `rst_n` = 0 mid-clock → `sel` = 0, `busy` = 0, `valid` = 0, `data` = 0 immediately, without waiting for a clock edge.
- **Single scan** (N = 12, SETTLE = 1): bench mux model drives `mux_y` = pattern[`sel`] with pattern 0xA5C; pulse `start` → `sel` steps 0..11 every 2 cycles, `valid` is a single pulse 24 edges after E0, `data` = 0xA5C, `busy` drops with `valid`, and `data` holds 0xA5C afterwards.
- **Settle masking:** force `mux_y` to the inverted value during every SETTLE cycle and the correct value during SAMPLE → `data` = 0xA5C.
- **Start while busy:** pulse `start` at cycles 5 and 23 after E0 → exactly one `valid` pulse, with no extra scan.
- **Continuous mode:** `cont` = 1; pattern changes 0x0F0 → 0x123 between scans → consecutive `valid` pulses exactly 24 cycles apart with `data` 0x0F0 then 0x123, and `busy` never drops. Clearing `cont` ends after the current scan.
- **Reset mid-scan and SETTLE = 0 build:**
  - Assert `rst_n` at `sel` = 6 after a prior `data` = 0xFFF → `data` = 0 and no `valid`. A fresh `start` then completes normally.
  - With SETTLE = 0, pattern 0x801 → `valid` 12 edges after E0 and `data` = 0x801.
